// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with almost-full/empty thresholds, sticky error flags,
// a synchronous flush, and either a registered read port or first-word-fall-through.
module sync_fifo_param #(
    parameter int DATA_W    = 8,
    parameter int DEPTH     = 8,
    parameter int AF_THRESH = DEPTH - 2,
    parameter int AE_THRESH = 2,
    parameter int FWFT      = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clear,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        data_in,
    output logic                     full,
    output logic                     almost_full,
    output logic                     overflow,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        data_out,
    output logic                     rd_valid,
    output logic                     empty,
    output logic                     almost_empty,
    output logic                     underflow,
    output logic [$clog2(DEPTH):0]   fifo_words
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              wr_acc;
    logic              rd_acc;

    assign full         = (count == DEPTH_C);
    assign empty        = (count == '0);
    assign almost_full  = (count >= AF_C);
    assign almost_empty = (count <= AE_C);
    assign fifo_words   = count;

    // Acceptance looks only at the flags from the start of the cycle.
    assign wr_acc = wr_en & ~full;
    assign rd_acc = rd_en & ~empty;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
            if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
            if (wr_acc && !rd_acc)
                count <= count + CW'(1);
            else if (rd_acc && !wr_acc)
                count <= count - CW'(1);
            if (wr_en && full)  overflow  <= 1'b1;
            if (rd_en && empty) underflow <= 1'b1;
        end
    end

    // Storage is never reset; a flush only moves the pointers.
    always_ff @(posedge clk) begin
        if (wr_acc && !rst && !clear)
            mem[wr_ptr] <= data_in;
    end

    generate
        if (FWFT != 0) begin : g_fwft
            assign data_out = mem[rd_ptr];
            assign rd_valid = ~empty;
        end else begin : g_std
            logic [DATA_W-1:0] dout_p1;
            logic              vld_p1;

            // Registered read stage: one clock from accepted rd_en to data.
            always_ff @(posedge clk) begin
                if (rst) begin
                    dout_p1 <= '0;
                    vld_p1  <= 1'b0;
                end else if (clear) begin
                    vld_p1  <= 1'b0;
                end else begin
                    vld_p1 <= rd_acc;
                    if (rd_acc) dout_p1 <= mem[rd_ptr];
                end
            end

            assign data_out = dout_p1;
            assign rd_valid = vld_p1;
        end
    endgenerate

endmodule
